// File: rtl/uart_tx_pkg.sv
// Shared types for the UART TX sequencer: sequencer state encoding and requester IDs.
package uart_tx_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_CLR = 2'd2,
    ST_GAP      = 2'd3
  } tx_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_AUX = 1'b1
  } req_id_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with flush; head byte is presented combinationally on data_o.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge i_Clock) begin
    if (reset || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge i_Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Round-robin merge of CPU and AUX byte streams into one FIFO, drained into a UART
// transmitter through its DV/Done handshake with an optional inter-byte gap.
module uart_tx_sequencer
  import uart_tx_pkg::*;
#(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned GAP_CLKS = 0
) (
  input  logic              i_Clock,
  input  logic              reset,
  input  logic              i_cpu_valid,
  input  logic [BYTE_W-1:0] i_cpu_data,
  output logic              o_cpu_ready,
  input  logic              i_aux_valid,
  input  logic [BYTE_W-1:0] i_aux_data,
  output logic              o_aux_ready,
  input  logic              i_flush,
  output logic              o_Tx_DV,
  output logic [BYTE_W-1:0] o_Tx_Byte,
  input  logic              i_Tx_Done,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_busy
);

  localparam int unsigned GAP_W = 8;

  tx_state_e         state_q;
  req_id_e           last_grant_q;
  req_id_e           last_grant_d;
  logic [GAP_W-1:0]  gap_q;
  logic              push_cpu;
  logic              push_aux;
  logic              push;
  logic              pop;
  logic [BYTE_W-1:0] push_data;
  logic [BYTE_W-1:0] head;
  logic              fifo_empty;
  logic              fifo_full;

  // Readies are combinational; when both request, the one not granted last wins.
  assign o_cpu_ready = ~fifo_full & ~i_flush & (~i_aux_valid | (last_grant_q == REQ_AUX));
  assign o_aux_ready = ~fifo_full & ~i_flush & (~i_cpu_valid | (last_grant_q == REQ_CPU));
  assign push_cpu    = i_cpu_valid & o_cpu_ready;
  assign push_aux    = i_aux_valid & o_aux_ready;
  assign push        = push_cpu | push_aux;
  assign push_data   = push_cpu ? i_cpu_data : i_aux_data;

  // Never launch while Done is still high so the transmitter cannot re-send.
  assign pop = (state_q == ST_IDLE) & ~fifo_empty & ~i_flush & ~i_Tx_Done;

  assign o_empty = fifo_empty;
  assign o_full  = fifo_full;
  assign o_busy  = ~fifo_empty | (state_q != ST_IDLE);

  always_comb begin
    last_grant_d = last_grant_q;
    if (push_cpu)      last_grant_d = REQ_CPU;
    else if (push_aux) last_grant_d = REQ_AUX;
  end

  always_ff @(posedge i_Clock) begin
    if (reset) last_grant_q <= REQ_AUX;
    else       last_grant_q <= last_grant_d;
  end

  uart_tx_fifo #(
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .i_Clock (i_Clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (i_flush),
    .data_i  (push_data),
    .data_o  (head),
    .count_o (o_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= '0;
      gap_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            o_Tx_Byte <= head;
            o_Tx_DV   <= 1'b1;
            state_q   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (i_Tx_Done) begin
            o_Tx_DV <= 1'b0;
            state_q <= ST_WAIT_CLR;
          end
        end
        ST_WAIT_CLR: begin
          if (!i_Tx_Done) begin
            if (GAP_CLKS == 0) begin
              state_q <= ST_IDLE;
            end else begin
              gap_q   <= GAP_W'(GAP_CLKS);
              state_q <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_q <= GAP_W'(1)) begin
            gap_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: begin
          o_Tx_DV <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Self-checking bench for uart_tx_sequencer: queue scoreboard, vector table,
// hand-written handshake/gap/full/reset sequences and a randomized run.
module tb_uart_tx_sequencer;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned GAP    = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cpu_valid, i_aux_valid, i_flush, i_Tx_Done;
  logic [7:0]  i_cpu_data, i_aux_data;
  logic        o_cpu_ready, o_aux_ready, o_Tx_DV, o_empty, o_full, o_busy;
  logic [7:0]  o_Tx_Byte;
  logic [ADDR_W:0] o_count;

  always #5 clk = ~clk;

  uart_tx_sequencer #(.ADDR_W(ADDR_W), .GAP_CLKS(GAP)) dut (
    .i_Clock     (clk),
    .reset       (rst),
    .i_cpu_valid (i_cpu_valid),
    .i_cpu_data  (i_cpu_data),
    .o_cpu_ready (o_cpu_ready),
    .i_aux_valid (i_aux_valid),
    .i_aux_data  (i_aux_data),
    .o_aux_ready (o_aux_ready),
    .i_flush     (i_flush),
    .o_Tx_DV     (o_Tx_DV),
    .o_Tx_Byte   (o_Tx_Byte),
    .i_Tx_Done   (i_Tx_Done),
    .o_count     (o_count),
    .o_empty     (o_empty),
    .o_full      (o_full),
    .o_busy      (o_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bytes expected to reach the transmitter, in order.
  logic [7:0] ref_q[$];
  logic [7:0] tx_log[$];
  logic       m_last_aux;
  logic       m_acc_c, m_acc_a;
  logic       pre_cr, pre_ar;
  logic       dv_prev;
  logic       auto_tx;
  int         tx_lat;
  int         k_cnt;

  typedef struct {
    logic       cv;
    logic [7:0] cd;
    logic       av;
    logic [7:0] ad;
    logic       fl;
    logic       exp_cr;
    logic       exp_ar;
    logic [4:0] exp_cnt;
    logic       exp_dv;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock; then scoreboard any new byte and run the transmitter model.
  task automatic step();
    @(posedge clk);
    #1;
    if (o_Tx_DV && !dv_prev) begin
      chk("dv_rise_while_done_low", 32'(i_Tx_Done), 0);
      n_cmp++;
      if (ref_q.size() == 0) begin
        n_bad++;
        $display("FAIL tx_byte_unexpected: got 0x%0h, want no transfer", o_Tx_Byte);
      end else begin
        logic [7:0] exp_b;
        exp_b = ref_q.pop_front();
        if (o_Tx_Byte !== exp_b) begin
          n_bad++;
          $display("FAIL tx_byte: got 0x%0h, want 0x%0h", o_Tx_Byte, exp_b);
        end
      end
      tx_log.push_back(o_Tx_Byte);
    end
    dv_prev = o_Tx_DV;
    if (auto_tx) begin
      if (!o_Tx_DV) begin
        if (i_Tx_Done) tx_lat = int'($urandom_range(0, 3));
        i_Tx_Done = 1'b0;
        k_cnt = 0;
      end else if (!i_Tx_Done) begin
        if (k_cnt >= tx_lat) i_Tx_Done = 1'b1;
        else k_cnt++;
      end
    end
  endtask

  // Drive one cycle of requests, predict readies/acceptance, advance, check occupancy.
  task automatic cycle(input logic cv, input logic [7:0] cd, input logic av,
                       input logic [7:0] ad, input logic fl);
    logic full, er_c, er_a;
    i_cpu_valid = cv; i_cpu_data = cd;
    i_aux_valid = av; i_aux_data = ad;
    i_flush = fl;
    #1;
    full = (ref_q.size() >= DEPTH);
    er_c = !full && !fl && (!av || m_last_aux);
    er_a = !full && !fl && (!cv || !m_last_aux);
    pre_cr = o_cpu_ready;
    pre_ar = o_aux_ready;
    chk("cpu_ready", 32'(o_cpu_ready), 32'(er_c));
    chk("aux_ready", 32'(o_aux_ready), 32'(er_a));
    m_acc_c = cv && er_c;
    m_acc_a = av && er_a && !m_acc_c;
    if (fl) ref_q.delete();
    else if (m_acc_c) begin ref_q.push_back(cd); m_last_aux = 1'b0; end
    else if (m_acc_a) begin ref_q.push_back(ad); m_last_aux = 1'b1; end
    step();
    chk("count", 32'(o_count), 32'(ref_q.size()));
  endtask

  task automatic idle();
    cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_cpu_valid = 1'b0; i_aux_valid = 1'b0; i_flush = 1'b0;
    i_cpu_data = 8'h00; i_aux_data = 8'h00;
    i_Tx_Done = 1'b0; auto_tx = 1'b0; tx_lat = 0; k_cnt = 0;
    ref_q.delete();
    step();
    step();
    rst = 1'b0;
    ref_q.delete();
    tx_log.delete();
    m_last_aux = 1'b1;
    dv_prev = 1'b0;
  endtask

  // Complete the byte in SEND manually, then idle until the sequencer can launch again.
  task automatic finish_byte();
    i_Tx_Done = 1'b1;
    for (int i = 0; i < 8 && o_Tx_DV; i++) idle();
    chk("dv_drop_after_done", 32'(o_Tx_DV), 0);
    i_Tx_Done = 1'b0;
    repeat (GAP + 1) idle();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    auto_tx = 1'b1;
    while ((o_busy || ref_q.size() != 0) && n < 800) begin
      idle();
      n++;
    end
    chk({name, "_model_empty"}, 32'(ref_q.size()), 0);
    chk({name, "_busy"}, 32'(o_busy), 0);
    chk({name, "_count"}, 32'(o_count), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ci, ai, n;
    // Done held low: 0x01 stays in SEND; flush discards queued bytes only.
    vecs[0] = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd1, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h02, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1, 8'h01};
    vecs[2] = '{1'b1, 8'h03, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1, 8'h01};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 8'hB3, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 8'h01};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 8'hB4, 1'b0, 1'b1, 1'b1, 5'd4, 1'b1, 8'h01};
    vecs[5] = '{1'b1, 8'h0F, 1'b1, 8'hBF, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 8'h01};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 8'h01};
    vecs[7] = '{1'b1, 8'h04, 1'b1, 8'hB5, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1, 8'h01};

    do_reset();
    chk("rst_dv", 32'(o_Tx_DV), 0);
    chk("rst_byte", 32'(o_Tx_Byte), 0);
    chk("rst_count", 32'(o_count), 0);
    chk("rst_empty", 32'(o_empty), 1);
    chk("rst_full", 32'(o_full), 0);
    chk("rst_busy", 32'(o_busy), 0);

    // Single CPU byte: latency, Done handshake, busy release after gap.
    cycle(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    chk("t1_dv_edge_n", 32'(o_Tx_DV), 0);
    idle();
    chk("t1_dv_edge_n1", 32'(o_Tx_DV), 1);
    chk("t1_byte", 32'(o_Tx_Byte), 32'h55);
    chk("t1_busy_send", 32'(o_busy), 1);
    i_Tx_Done = 1'b1;
    idle();
    chk("t1_dv_drop", 32'(o_Tx_DV), 0);
    i_Tx_Done = 1'b0;
    repeat (GAP) idle();
    chk("t1_busy_in_gap", 32'(o_busy), 1);
    idle();
    chk("t1_busy_done", 32'(o_busy), 0);

    // Vector table: arbitration, flush, latency with transmitter stalled.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      cycle(vecs[v].cv, vecs[v].cd, vecs[v].av, vecs[v].ad, vecs[v].fl);
      chk($sformatf("tbl%0d_cpu_ready", v), 32'(pre_cr), 32'(vecs[v].exp_cr));
      chk($sformatf("tbl%0d_aux_ready", v), 32'(pre_ar), 32'(vecs[v].exp_ar));
      chk($sformatf("tbl%0d_count", v), 32'(o_count), 32'(vecs[v].exp_cnt));
      chk($sformatf("tbl%0d_dv", v), 32'(o_Tx_DV), 32'(vecs[v].exp_dv));
      chk($sformatf("tbl%0d_byte", v), 32'(o_Tx_Byte), 32'(vecs[v].exp_byte));
    end
    drain("tbl");
    chk("tbl_log_len", 32'(tx_log.size()), 2);
    if (tx_log.size() == 2) begin
      chk("tbl_log0", 32'(tx_log[0]), 32'h01);
      chk("tbl_log1", 32'(tx_log[1]), 32'h04);
    end

    // Both requesters always valid: strict alternation starting with CPU.
    do_reset();
    auto_tx = 1'b1;
    ci = 0; ai = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(8'h10 + ci), 1'b1, 8'(8'hA0 + ai), 1'b0);
      if (m_acc_c) ci++;
      if (m_acc_a) ai++;
    end
    drain("t2");
    chk("t2_log_len", 32'(tx_log.size()), 8);
    for (int j = 0; j < tx_log.size() && j < 8; j++)
      chk($sformatf("t2_order%0d", j), 32'(tx_log[j]),
          (j % 2 == 0) ? 32'(8'h10 + j / 2) : 32'(8'hA0 + j / 2));

    // Push during pop at count 5, fill to full, push at full during pop.
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0, 8'h00, 1'b0);
    chk("t4_count5", 32'(o_count), 5);
    finish_byte();
    cycle(1'b1, 8'h66, 1'b0, 8'h00, 1'b0);
    chk("t4_count_kept", 32'(o_count), 5);
    chk("t4_dv", 32'(o_Tx_DV), 1);
    chk("t4_byte", 32'(o_Tx_Byte), 32'h61);
    for (int i = 0; i < 11; i++) cycle(1'b1, 8'(8'h67 + i), 1'b0, 8'h00, 1'b0);
    chk("t3_full", 32'(o_full), 1);
    chk("t3_count16", 32'(o_count), 16);
    cycle(1'b1, 8'h77, 1'b1, 8'hE7, 1'b0);
    chk("t3_cpu_ready_full", 32'(o_cpu_ready), 0);
    chk("t3_aux_ready_full", 32'(o_aux_ready), 0);
    finish_byte();
    cycle(1'b1, 8'h78, 1'b0, 8'h00, 1'b0);
    chk("t4_full_pop_count", 32'(o_count), 15);
    chk("t4_full_pop_byte", 32'(o_Tx_Byte), 32'h62);
    drain("t3");
    chk("t3_log_len", 32'(tx_log.size()), 18);
    for (int j = 0; j < tx_log.size() && j < 18; j++)
      chk($sformatf("t3_order%0d", j), 32'(tx_log[j]), 32'(8'h60 + j));

    // Gap timing: WAIT_CLR and IDLE each take one clock on top of GAP.
    do_reset();
    cycle(1'b1, 8'h31, 1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h32, 1'b0, 8'h00, 1'b0);
    i_Tx_Done = 1'b1;
    idle();
    chk("t6_dv_drop", 32'(o_Tx_DV), 0);
    i_Tx_Done = 1'b0;
    n = 0;
    while (!o_Tx_DV && n < 20) begin
      idle();
      n++;
    end
    chk("t6_gap_edges", 32'(n), 32'(GAP + 2));
    chk("t6_byte", 32'(o_Tx_Byte), 32'h32);

    // Reset while a byte is in SEND with one more queued.
    cycle(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    chk("t6_pre_rst_count", 32'(o_count), 1);
    rst = 1'b1;
    ref_q.delete();
    step();
    chk("t6_rst_dv", 32'(o_Tx_DV), 0);
    chk("t6_rst_count", 32'(o_count), 0);
    chk("t6_rst_busy", 32'(o_busy), 0);
    rst = 1'b0;
    m_last_aux = 1'b1;
    dv_prev = 1'b0;

    // Randomized traffic against the queue model.
    do_reset();
    auto_tx = 1'b1;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 99) < 45), 8'($urandom), ($urandom_range(0, 99) < 45),
            8'($urandom), ($urandom_range(0, 99) < 2));
    end
    drain("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
